keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/kp_sync.sv | 21 ++
 rtl/keypad_scanner.sv | 125 ++++++++++++
 tb/tb_keypad_scanner.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } kp_state_t;

  localparam int SCAN_DIV_DEFAULT = 50000;
  localparam int DB_CNT_DEFAULT   = 20;

  // Nibble {row, col} holds the key code; row 0 / col 0 is the top-left key.
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction

  function automatic logic [1:0] lowest_row(input logic [3:0] rs);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rs[2]) idx = 2'd2;
    if (!rs[1]) idx = 2'd1;
    if (!rs[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchroniser for the asynchronous, active-low row lines.
module kp_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates one low column, debounces press and
// release, and emits a single key_valid strobe per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int DB_CNT   = DB_CNT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] decode,
  output logic       key_valid
);

  localparam int DWW = $clog2(SCAN_DIV + 1);
  localparam int DBW = $clog2(DB_CNT + 1);

  kp_state_t      state, state_nxt;
  logic [1:0]     c, c_nxt;
  logic [1:0]     r, r_nxt;
  logic [DWW-1:0] dwell_cnt;
  logic [DBW-1:0] db_cnt, db_cnt_nxt;
  logic [3:0]     rs;
  logic           sample;

  kp_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rs)
  );

  // Rows are only trusted on the final dwell cycle, after the column has settled.
  assign sample = (dwell_cnt == DWW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (sample) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SCAN;
      c      <= 2'd0;
      r      <= 2'd0;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      c      <= c_nxt;
      r      <= r_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    c_nxt      = c;
    r_nxt      = r;
    db_cnt_nxt = db_cnt;
    case (state)
      SCAN: begin
        if (sample) begin
          if (rs != 4'hF) begin
            r_nxt      = lowest_row(rs);
            db_cnt_nxt = '0;
            state_nxt  = DEBOUNCE;
          end else begin
            c_nxt = c + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (!rs[r]) begin
            if (db_cnt == DBW'(DB_CNT - 1)) begin
              db_cnt_nxt = '0;
              state_nxt  = EMIT;
            end else begin
              db_cnt_nxt = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_nxt = '0;
            c_nxt      = c + 2'd1;
            state_nxt  = SCAN;
          end
        end
      end
      EMIT: begin
        db_cnt_nxt = '0;
        state_nxt  = RELEASE;
      end
      RELEASE: begin
        // The column stays frozen, so only the held key's column is watched here.
        if (sample) begin
          if (rs == 4'hF) begin
            if (db_cnt == DBW'(DB_CNT - 1)) begin
              db_cnt_nxt = '0;
              c_nxt      = c + 2'd1;
              state_nxt  = SCAN;
            end else begin
              db_cnt_nxt = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = SCAN;
      end
    endcase
  end

  assign col       = ~(4'b0001 << c);
  assign key_valid = (state == EMIT);
  assign decode    = key_valid ? key_lookup(r, c) : 4'h0;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a keypad matrix model drives row from col, and a
// scoreboard queue holds the key codes expected on each key_valid strobe.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] decode;
  logic       key_valid;

  logic [15:0] pressed;
  logic [3:0]  sb[$];
  int          total;
  int          bad;

  keypad_scanner #(
    .SCAN_DIV (4),
    .DB_CNT   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .decode    (decode),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int ci = 0; ci < 4; ci++) begin
      if (!col[ci]) begin
        for (int ri = 0; ri < 4; ri++) begin
          if (pressed[ri*4 + ci]) row[ri] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", {28'd0, decode}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("decode", {28'd0, decode}, {28'd0, sb.pop_front()});
      end
    end else begin
      checkOutput("idle_decode", {28'd0, decode}, 32'd0);
    end
  end

  task automatic waitCol(input logic [3:0] target, input int limit, input string tag);
    int n;
    n = 0;
    while (col !== target && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, {28'd0, col}, {28'd0, target});
  endtask

  // Press a key set, expect one code, confirm the column freezes, then release.
  task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] code,
                               input logic [3:0] colExp, input int hold);
    sb.push_back(code);
    pressed = mask;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("frozen_col", {28'd0, col}, {28'd0, colExp});
    repeat (hold - 50) @(posedge clk);
    #1;
    checkOutput("held_col", {28'd0, col}, {28'd0, colExp});
    pressed = 16'h0000;
  endtask

  task automatic settle(input string tag);
    repeat (40) @(posedge clk);
    #1;
    checkOutput(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    pressed = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_col", {28'd0, col}, 32'hE);
    checkOutput("rst_valid", {31'd0, key_valid}, 32'd0);
    checkOutput("rst_decode", {28'd0, decode}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle rotation: one column step every 4 cycles.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("scan_col", {28'd0, col}, {28'd0, ~(4'b0001 << (k / 4))});
    end

    $display("[TB] key 5");
    applyStimulus(16'h0020, 4'h5, 4'b1101, 60);
    settle("sb_key5");

    $display("[TB] key D long hold");
    applyStimulus(16'h8000, 4'hD, 4'b0111, 200);
    waitCol(4'b1110, 40, "resume_col");
    settle("sb_keyD");

    $display("[TB] bounce on key 7");
    waitCol(4'b1101, 40, "bounce_sync_a");
    waitCol(4'b1110, 40, "bounce_sync_b");
    pressed = 16'h0100;
    repeat (5) @(posedge clk);
    #1 pressed = 16'h0000;
    settle("sb_bounce");
    applyStimulus(16'h0100, 4'h7, 4'b1110, 60);
    settle("sb_key7");

    $display("[TB] rows 0 and 2 together, then key 0");
    applyStimulus(16'h0101, 4'h1, 4'b1110, 60);
    settle("sb_multi");
    applyStimulus(16'h1000, 4'h0, 4'b1110, 60);
    settle("sb_key0");

    $display("[TB] reset during debounce of key A");
    waitCol(4'b1110, 40, "rst_sync");
    sb.push_back(4'hA);
    pressed = 16'h0008;
    waitCol(4'b0111, 40, "rst_reach_col3");
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_col", {28'd0, col}, 32'hE);
    checkOutput("abort_valid", {31'd0, key_valid}, 32'd0);
    repeat (60) @(posedge clk);
    #1 pressed = 16'h0000;
    settle("sb_keyA");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
